// File: rtl/seq_shifter.sv
// Multi-cycle 16-bit shifter/rotator: one shift stage per cycle (distance 1, 2, 4, 8),
// fixed 4-cycle latency, registered result with a one-cycle done pulse.
module seq_shifter (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] In,
   input  logic [3:0]  Cnt,
   input  logic [1:0]  Op,
   output logic        busy,
   output logic        done,
   output logic [15:0] Out
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [1:0] OP_ROL = 2'b00;
   localparam logic [1:0] OP_SLL = 2'b01;
   localparam logic [1:0] OP_ROR = 2'b10;
   localparam logic [1:0] OP_SRL = 2'b11;

   state_t      state_q, state_d;
   logic [1:0]  k_q;
   logic [15:0] work_q;
   logic [3:0]  cnt_q;
   logic [1:0]  op_q;
   logic [15:0] stage;
   logic [4:0]  sh;
   logic        accept;

   // new work is taken from IDLE or straight out of DONE (back-to-back)
   assign accept = start && (state_q == IDLE || state_q == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (k_q == 2'd3) state_d = DONE;
         DONE:    state_d = start ? SHIFT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == SHIFT);
      done = (state_q == DONE);
   end

   // single shift stage: distance 2^k, applied only when that count bit is set
   always_comb begin
      sh    = 5'd1 << k_q;
      stage = work_q;
      if (cnt_q[k_q]) begin
         case (op_q)
            OP_ROL:  stage = (work_q << sh) | (work_q >> (5'd16 - sh));
            OP_SLL:  stage = work_q << sh;
            OP_ROR:  stage = (work_q >> sh) | (work_q << (5'd16 - sh));
            OP_SRL:  stage = work_q >> sh;
            default: stage = work_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work_q <= '0;
         cnt_q  <= '0;
         op_q   <= '0;
         k_q    <= '0;
         Out    <= '0;
      end else if (accept) begin
         work_q <= In;
         cnt_q  <= Cnt;
         op_q   <= Op;
         k_q    <= '0;
      end else if (state_q == SHIFT) begin
         work_q <= stage;
         k_q    <= k_q + 2'd1;
         if (k_q == 2'd3) Out <= stage;
      end
   end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: latency, opcodes, max count, busy/back-to-back start,
// async reset mid-op and idle stability, all against hand-computed results.
module tb_seq_shifter;

   logic        clk = 0;
   logic        rst;
   logic        start;
   logic [15:0] In;
   logic [3:0]  Cnt;
   logic [1:0]  Op;
   logic        busy, done;
   logic [15:0] Out;

   int          errs = 0;
   int          nchk = 0;
   logic [15:0] out_hold;

   seq_shifter dut (
      .clk(clk), .rst(rst), .start(start), .In(In), .Cnt(Cnt), .Op(Op),
      .busy(busy), .done(done), .Out(Out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      nchk++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // one operation from IDLE; inputs are scrambled after the accept edge
   task automatic do_op(input string tag, input logic [15:0] a, input logic [3:0] c,
                        input logic [1:0] o, input logic [15:0] exp);
      int bc, oc;
      @(negedge clk);
      In = a; Cnt = c; Op = o; start = 1;
      bc = 0; oc = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = 0; In = ~a; Cnt = ~c; Op = ~o;
         if (busy && !done) bc++;
         if (Out !== out_hold) oc++;
      end
      chk({tag, "_busycyc"}, 16'(bc), 16'd4);
      chk({tag, "_outhold"}, 16'(oc), 16'd0);
      @(negedge clk);
      chk({tag, "_done"}, {15'd0, done}, 16'd1);
      chk({tag, "_busy0"}, {15'd0, busy}, 16'd0);
      chk({tag, "_out"}, Out, exp);
      out_hold = exp;
   endtask

   initial begin
      int dc, bad;
      rst = 1; start = 0; In = 16'h5555; Cnt = 4'hF; Op = 2'b11;
      #2;
      chk("rst_out", Out, 16'h0000);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_done", {15'd0, done}, 16'd0);
      out_hold = 16'h0000;
      repeat (2) @(negedge clk);
      rst = 0;

      do_op("srl",    16'hF00F, 4'd4,  2'b11, 16'h0F00);
      do_op("rol1",   16'h8001, 4'd1,  2'b00, 16'h0003);
      do_op("sll1",   16'h8001, 4'd1,  2'b01, 16'h0002);
      do_op("sll15",  16'hFFFF, 4'd15, 2'b01, 16'h8000);
      do_op("ror15",  16'h0001, 4'd15, 2'b10, 16'h0002);
      do_op("srl15",  16'hFFFF, 4'd15, 2'b11, 16'h0001);
      do_op("ror1",   16'h0001, 4'd1,  2'b10, 16'h8000);
      do_op("rol4",   16'h1234, 4'd4,  2'b00, 16'h2341);
      do_op("cnt0",   16'hBEEF, 4'd0,  2'b11, 16'hBEEF);
      do_op("ror6",   16'h00FF, 4'd6,  2'b10, 16'hFC03);

      // start while busy is ignored; then back-to-back via held start
      @(negedge clk);
      In = 16'h1234; Cnt = 4'd0; Op = 2'b00; start = 1;
      dc = 0;
      @(negedge clk); start = 0;
      if (done) dc++;
      @(negedge clk);
      In = 16'hFFFF; Cnt = 4'd8; Op = 2'b11; start = 1;
      if (done) dc++;
      @(negedge clk); start = 0;
      if (done) dc++;
      @(negedge clk);
      if (done) dc++;
      chk("busy_ign_busy", {15'd0, busy}, 16'd1);
      @(negedge clk);
      if (done) dc++;
      chk("busy_ign_ndone", 16'(dc), 16'd1);
      chk("busy_ign_out", Out, 16'h1234);
      In = 16'h00F0; Cnt = 4'd4; Op = 2'b01; start = 1;
      @(negedge clk);
      chk("b2b_busy", {15'd0, busy}, 16'd1);
      In = 16'h0000; Cnt = 4'd0; Op = 2'b00;
      repeat (3) @(negedge clk);
      chk("b2b_nodone", {15'd0, done}, 16'd0);
      @(negedge clk);
      chk("b2b_done", {15'd0, done}, 16'd1);
      chk("b2b_out", Out, 16'h0F00);
      start = 0;
      @(negedge clk);
      chk("b2b_idle", {14'd0, busy, done}, 16'd0);

      // idle stability with toggling inputs
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         In = 16'($urandom); Cnt = 4'($urandom); Op = 2'($urandom);
         @(negedge clk);
         if (Out !== 16'h0F00 || busy || done) bad++;
      end
      chk("idle_stable", 16'(bad), 16'd0);

      // async reset during stage k=2
      @(negedge clk);
      In = 16'hABCD; Cnt = 4'd8; Op = 2'b00; start = 1;
      @(negedge clk); start = 0;
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1;
      #1;
      chk("mrst_out", Out, 16'h0000);
      chk("mrst_flags", {14'd0, busy, done}, 16'd0);
      @(negedge clk);
      rst = 0;
      dc = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done || busy) dc++;
      end
      chk("mrst_nodone", 16'(dc), 16'd0);
      out_hold = 16'h0000;
      do_op("post_rst", 16'hABCD, 4'd8, 2'b00, 16'hCDAB);

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Multi-cycle 16-bit shifter/rotator built around one single-stage shift datapath. The datapath applies one shift stage per cycle, with distances 1, 2, 4 and 8.
- Sits between operand decode and the writeback mux of the execute unit. It consumes the 16-bit operand, the 4-bit count and the shift opcode, and hands back a registered result with a done pulse.
- Fixed latency of 4 cycles regardless of count. This replaces the fully combinational barrel shifter on the critical path.

Parameters:
- None. Data width is fixed at 16 bits and the count at 4 bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on rising clk edge when accepted
- In  input  16  operand; captured on accepted start
- Cnt  input  4  shift amount 0..15; captured on accepted start
- Op  input  2  00 = rotate left, 01 = shift left logical, 10 = rotate right, 11 = shift right logical; captured on accepted start
- busy  output  1  high while an operation is in flight (state SHIFT)
- done  output  1  one-cycle pulse; Out is valid in this cycle
- Out  output  16  result register; holds value until next accepted start completes

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high. While rst is asserted: state=IDLE, busy=0, done=0, Out=0x0000, stage index=0, captured operand/count/op=0. Effect is immediate, not clock-gated.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge is accepted: capture In, Cnt and Op into the working register; stage index k=0; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, one edge per stage, k=0..3:
  - If captured Cnt[k]=1, the working register is replaced by itself shifted/rotated by 2^k per Op. Otherwise it is unchanged.
  - Left shift fills zeros at the LSBs. Right logical shift fills zeros at the MSBs.
  - Rotates wrap bits end-around with no loss.
  - At k=3, the stage result is written to Out and the next state is DONE. Otherwise k increments.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - start=1 in this cycle is accepted (back-to-back); next state is SHIFT with new operands.
  - Otherwise next state is IDLE.
- Latency: start sampled at edge E0; stages at E1..E4; done high in the cycle following E4. Throughput is one operation per 5 cycles.
- Start handling:
  - start while busy=1 is ignored; captured values are not disturbed.
  - start held high continuously launches a new operation on every DONE cycle.
- Out:
  - Changes only at the final stage edge, or on reset.
  - Holds its value through IDLE and through the SHIFT of the next operation.
- Cnt=0: result equals captured In; latency still 4 cycles.
- Inputs In, Cnt and Op may change freely after the accepted start edge without affecting the result.
- Reset mid-operation: the operation is abandoned, no done pulse is produced, Out=0x0000, and the block returns to IDLE.
- done and busy are never high together. Neither is high in IDLE.

Test Plan:
- SRL: In=0xF00F, Cnt=4, Op=11, one-cycle start -> busy high 4 cycles; done pulses in cycle 5 after start edge; Out=0x0F00.
- ROL/SLL: In=0x8001, Cnt=1, Op=00 -> Out=0x0003. Repeat with Op=01 -> Out=0x0002.
- Max count: In=0xFFFF, Cnt=15, Op=01 -> Out=0x8000. In=0x0001, Cnt=15, Op=10 -> Out=0x0002. In=0xFFFF, Cnt=15, Op=11 -> Out=0x0001.
- Start while busy:
  - In=0x1234, Cnt=0, Op=00 started.
  - Two cycles later, pulse start with In=0xFFFF, Cnt=8, Op=11.
  - Expected: second request ignored; Out=0x1234 with a single done pulse.
  - Then hold start high through DONE with In=0x00F0, Cnt=4, Op=01: accepted back-to-back, next done gives Out=0x0F00.
- Reset mid-op:
  - In=0xABCD, Cnt=8, Op=00 started.
  - Assert rst asynchronously between edges during SHIFT stage 2.
  - Expected: Out=0x0000, busy=0, done=0 immediately, with no done pulse afterwards.
  - After rst release, a new start with In=0xABCD, Cnt=8, Op=00 gives Out=0xCDAB.
- Idle stability: no start for 20 cycles after an operation giving Out=0x0F00 -> Out stays 0x0F00; done and busy stay 0; In/Cnt/Op toggling has no effect.
